// File: rtl/ram_responder.sv
// Byte-addressed, big-endian RAM responder for the MFA/MOC memory handshake with configurable wait states.
// Define RAM_ALIGN_CHECK_EN to abort misaligned halfword/word accesses instead of forcing them aligned.
module ram_responder #(
    parameter int ADDR_W      = 9,
    parameter int DEPTH       = 512,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              main_clk,
    input  logic              reset,
    input  logic              mfa,
    input  logic              rw,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       data_in,
    output logic [31:0]       data_out,
    output logic              moc,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
    localparam logic [1:0] SZ_BYTE   = 2'b00;
    localparam logic [1:0] SZ_HALF   = 2'b01;

    logic [7:0] memory [DEPTH];

    state_t            state_r;
    state_t            state_s;
    logic [3:0]        cnt_r;
    logic [3:0]        cnt_s;
    logic              capture_s;
    logic [ADDR_W-1:0] addr_r;
    logic              rw_r;
    logic [1:0]        size_r;
    logic              sext_r;
    logic [31:0]       wdata_r;
    logic [31:0]       data_out_r;
    logic [31:0]       data_out_s;
    logic              moc_r;
    logic              moc_s;
    logic              err_r;
    logic              err_s;

    logic [ADDR_W-1:0] base_s;
    logic [ADDR_W-1:0] addr1_s;
    logic [ADDR_W-1:0] addr2_s;
    logic [ADDR_W-1:0] addr3_s;
    logic [7:0]        rd_b0_s;
    logic [7:0]        rd_b1_s;
    logic [7:0]        rd_b2_s;
    logic [7:0]        rd_b3_s;
    logic [31:0]       rd_data_s;
    logic              abort_s;
    logic              mem_we_s;

    // Aligned base address of the captured access; a misaligned access that
    // is aborted never uses it, so forcing alignment is safe in both builds.
    always_comb begin
        base_s = addr_r;
        case (size_r)
            SZ_BYTE: base_s = addr_r;
            SZ_HALF: base_s = {addr_r[ADDR_W-1:1], 1'b0};
            default: base_s = {addr_r[ADDR_W-1:2], 2'b00};
        endcase
    end

    assign addr1_s = base_s + ADDR_W'(1);
    assign addr2_s = base_s + ADDR_W'(2);
    assign addr3_s = base_s + ADDR_W'(3);

`ifdef RAM_ALIGN_CHECK_EN
    // Misalignment detection: halfword needs an even address, word a multiple of four.
    always_comb begin
        case (size_r)
            SZ_BYTE: abort_s = 1'b0;
            SZ_HALF: abort_s = addr_r[0];
            default: abort_s = |addr_r[1:0];
        endcase
    end
`else
    assign abort_s = 1'b0;
`endif

    assign rd_b0_s = memory[base_s];
    assign rd_b1_s = memory[addr1_s];
    assign rd_b2_s = memory[addr2_s];
    assign rd_b3_s = memory[addr3_s];

    // Big-endian read assembly with right-justification and sign/zero extension.
    always_comb begin
        rd_data_s = 32'h0000_0000;
        case (size_r)
            SZ_BYTE: rd_data_s = {{24{sext_r & rd_b0_s[7]}}, rd_b0_s};
            SZ_HALF: rd_data_s = {{16{sext_r & rd_b0_s[7]}}, rd_b0_s, rd_b1_s};
            default: rd_data_s = {rd_b0_s, rd_b1_s, rd_b2_s, rd_b3_s};
        endcase
    end

    assign mem_we_s = (state_r == ST_ACCESS) && !rw_r && !abort_s;

    // Next-state and output logic of the request FSM.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        capture_s  = 1'b0;
        data_out_s = data_out_r;
        moc_s      = moc_r;
        err_s      = err_r;
        case (state_r)
            ST_IDLE: begin
                if (mfa) begin
                    capture_s = 1'b1;
                    if (WAIT_LOAD == 4'd0) begin
                        state_s = ST_ACCESS;
                        cnt_s   = 4'd0;
                    end else begin
                        state_s = ST_WAIT;
                        cnt_s   = WAIT_LOAD;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r <= 4'd1) begin
                    state_s = ST_ACCESS;
                    cnt_s   = 4'd0;
                end else begin
                    cnt_s = cnt_r - 4'd1;
                end
            end
            ST_ACCESS: begin
                state_s = ST_DONE;
                moc_s   = 1'b1;
                err_s   = abort_s;
                if (abort_s) begin
                    data_out_s = 32'h0000_0000;
                end else if (rw_r) begin
                    data_out_s = rd_data_s;
                end else begin
                    data_out_s = data_out_r;
                end
            end
            ST_DONE: begin
                // Four-phase handshake: wait for mfa to drop before accepting anything new.
                if (!mfa) begin
                    state_s = ST_IDLE;
                    moc_s   = 1'b0;
                    err_s   = 1'b0;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 4'd0;
                moc_s   = 1'b0;
                err_s   = 1'b0;
            end
        endcase
    end

    // FSM state, wait counter, captured request and registered outputs.
    always_ff @(posedge main_clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 4'd0;
            addr_r     <= '0;
            rw_r       <= 1'b0;
            size_r     <= 2'b00;
            sext_r     <= 1'b0;
            wdata_r    <= 32'h0000_0000;
            data_out_r <= 32'h0000_0000;
            moc_r      <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            data_out_r <= data_out_s;
            moc_r      <= moc_s;
            err_r      <= err_s;
            if (capture_s) begin
                addr_r  <= address;
                rw_r    <= rw;
                size_r  <= size;
                sext_r  <= sign_ext;
                wdata_r <= data_in;
            end
        end
    end

    // Byte-lane writes; the array is deliberately not reset and a write
    // reaching ACCESS commits even if reset arrives on that same edge.
    always_ff @(posedge main_clk) begin
        if (mem_we_s) begin
            case (size_r)
                SZ_BYTE: begin
                    memory[base_s] <= wdata_r[7:0];
                end
                SZ_HALF: begin
                    memory[base_s]  <= wdata_r[15:8];
                    memory[addr1_s] <= wdata_r[7:0];
                end
                default: begin
                    memory[base_s]  <= wdata_r[31:24];
                    memory[addr1_s] <= wdata_r[23:16];
                    memory[addr2_s] <= wdata_r[15:8];
                    memory[addr3_s] <= wdata_r[7:0];
                end
            endcase
        end
    end

    assign data_out = data_out_r;
    assign moc      = moc_r;
    assign err      = err_r;

endmodule

// File: tb/tb_ram_responder.sv
// Self-checking bench for ram_responder: table-driven accesses with a scoreboard,
// plus hand-written mfa-hold and mid-operation reset sequences.
module tb_ram_responder;

    localparam int AW = 9;
    localparam int WC = 1;

    logic          main_clk;
    logic          reset;
    logic          mfa;
    logic          rw;
    logic [1:0]    size;
    logic          sign_ext;
    logic [AW-1:0] address;
    logic [31:0]   data_in;
    logic [31:0]   data_out;
    logic          moc;
    logic          err;

    ram_responder #(.ADDR_W(AW), .DEPTH(512), .WAIT_CYCLES(WC)) dut (
        .main_clk (main_clk),
        .reset    (reset),
        .mfa      (mfa),
        .rw       (rw),
        .size     (size),
        .sign_ext (sign_ext),
        .address  (address),
        .data_in  (data_in),
        .data_out (data_out),
        .moc      (moc),
        .err      (err)
    );

    typedef struct {
        logic          rw;
        logic [1:0]    size;
        logic          sx;
        logic [AW-1:0] addr;
        logic [31:0]   din;
        logic          keep;
        logic [31:0]   exp_d;
        logic          exp_e;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_dout = 32'h0000_0000;

    initial main_clk = 1'b0;
    always #5 main_clk = ~main_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic r, input logic [1:0] s, input logic x,
                                input logic [AW-1:0] a, input logic [31:0] d,
                                input logic k, input logic [31:0] ed, input logic ee);
        vec_t v;
        v.rw = r; v.size = s; v.sx = x; v.addr = a; v.din = d;
        v.keep = k; v.exp_d = ed; v.exp_e = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic start_req(input vec_t v);
        exp_t e;
        @(negedge main_clk);
        mfa      = 1'b1;
        rw       = v.rw;
        size     = v.size;
        sign_ext = v.sx;
        address  = v.addr;
        data_in  = v.din;
        e.data   = v.keep ? model_dout : v.exp_d;
        e.err    = v.exp_e;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string tag);
        exp_t e;
        int   edges;
        edges = 0;
        do begin
            @(posedge main_clk);
            #1;
            edges++;
            if (edges == 1) begin
                // Inputs other than mfa must be ignored once captured.
                address  = AW'($urandom);
                data_in  = $urandom;
                size     = 2'($urandom);
                sign_ext = 1'($urandom);
                rw       = 1'($urandom);
            end
        end while (moc !== 1'b1 && edges < 40);
        e = sb.pop_front();
        if (moc !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: moc not seen after %0d edges", tag, edges);
        end else begin
            chk({tag, " latency"}, 32'(edges), 32'(WC + 2));
            chk({tag, " data"}, data_out, e.data);
            chk({tag, " err"}, {31'd0, err}, {31'd0, e.err});
        end
        model_dout = e.data;
    endtask

    task automatic release_req(input string tag);
        @(negedge main_clk);
        mfa = 1'b0;
        @(posedge main_clk);
        #1;
        chk({tag, " moc_clr"}, {31'd0, moc}, 32'd0);
        chk({tag, " err_clr"}, {31'd0, err}, 32'd0);
        chk({tag, " hold_dout"}, data_out, model_dout);
    endtask

    task automatic run_access(input vec_t v, input string tag);
        start_req(v);
        wait_done(tag);
        release_req(tag);
    endtask

    initial begin
        reset    = 1'b1;
        mfa      = 1'b0;
        rw       = 1'b1;
        size     = 2'b00;
        sign_ext = 1'b0;
        address  = '0;
        data_in  = 32'h0000_0000;

        dut.memory[0]   <= 8'hDE; dut.memory[1]  <= 8'hAD;
        dut.memory[2]   <= 8'hBE; dut.memory[3]  <= 8'hEF;
        dut.memory[4]   <= 8'h11; dut.memory[5]  <= 8'h22;
        dut.memory[6]   <= 8'h33; dut.memory[7]  <= 8'h44;
        dut.memory[8]   <= 8'h00; dut.memory[9]  <= 8'h00;
        dut.memory[10]  <= 8'h5A; dut.memory[12] <= 8'hC3;
        dut.memory[16]  <= 8'h00; dut.memory[17] <= 8'h00;
        dut.memory[18]  <= 8'h00; dut.memory[19] <= 8'h00;
        dut.memory[20]  <= 8'h00; dut.memory[21] <= 8'h00;
        dut.memory[511] <= 8'h00;

        // rw, size, sign_ext, address, data_in, keep previous data_out, expected data, expected err
        vecs.push_back(mk(1'b1, 2'b10, 1'b0, 9'd0,   32'h0,         1'b0, 32'hDEADBEEF, 1'b0));
        vecs.push_back(mk(1'b1, 2'b01, 1'b1, 9'd0,   32'h0,         1'b0, 32'hFFFFDEAD, 1'b0));
        vecs.push_back(mk(1'b1, 2'b01, 1'b0, 9'd2,   32'h0,         1'b0, 32'h0000BEEF, 1'b0));
        vecs.push_back(mk(1'b1, 2'b00, 1'b1, 9'd3,   32'h0,         1'b0, 32'hFFFFFFEF, 1'b0));
        vecs.push_back(mk(1'b1, 2'b00, 1'b0, 9'd1,   32'h0,         1'b0, 32'h000000AD, 1'b0));
        vecs.push_back(mk(1'b0, 2'b00, 1'b1, 9'd5,   32'hFFFFFF80,  1'b1, 32'h0,        1'b0));
        vecs.push_back(mk(1'b1, 2'b00, 1'b1, 9'd5,   32'h0,         1'b0, 32'hFFFFFF80, 1'b0));
        vecs.push_back(mk(1'b1, 2'b00, 1'b0, 9'd5,   32'h0,         1'b0, 32'h00000080, 1'b0));
        vecs.push_back(mk(1'b0, 2'b01, 1'b0, 9'd8,   32'hABCD1234,  1'b1, 32'h0,        1'b0));
        vecs.push_back(mk(1'b1, 2'b01, 1'b1, 9'd8,   32'h0,         1'b0, 32'h00001234, 1'b0));
`ifdef RAM_ALIGN_CHECK_EN
        vecs.push_back(mk(1'b1, 2'b10, 1'b0, 9'd6,   32'h0,         1'b0, 32'h00000000, 1'b1));
`else
        vecs.push_back(mk(1'b1, 2'b10, 1'b0, 9'd6,   32'h0,         1'b0, 32'h11803344, 1'b0));
`endif
        vecs.push_back(mk(1'b1, 2'b11, 1'b1, 9'd0,   32'h0,         1'b0, 32'hDEADBEEF, 1'b0));
`ifdef RAM_ALIGN_CHECK_EN
        vecs.push_back(mk(1'b1, 2'b01, 1'b0, 9'd1,   32'h0,         1'b0, 32'h00000000, 1'b1));
`else
        vecs.push_back(mk(1'b1, 2'b01, 1'b0, 9'd1,   32'h0,         1'b0, 32'h0000DEAD, 1'b0));
`endif
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 9'd16,  32'h01020304,  1'b1, 32'h0,        1'b0));
        vecs.push_back(mk(1'b1, 2'b10, 1'b0, 9'd16,  32'h0,         1'b0, 32'h01020304, 1'b0));
        vecs.push_back(mk(1'b1, 2'b00, 1'b1, 9'd18,  32'h0,         1'b0, 32'h00000003, 1'b0));
`ifdef RAM_ALIGN_CHECK_EN
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 9'd17,  32'hAABBCCDD,  1'b0, 32'h00000000, 1'b1));
        vecs.push_back(mk(1'b1, 2'b10, 1'b0, 9'd16,  32'h0,         1'b0, 32'h01020304, 1'b0));
        vecs.push_back(mk(1'b1, 2'b01, 1'b1, 9'd19,  32'h0,         1'b0, 32'h00000000, 1'b1));
`else
        vecs.push_back(mk(1'b0, 2'b10, 1'b0, 9'd17,  32'hAABBCCDD,  1'b1, 32'h0,        1'b0));
        vecs.push_back(mk(1'b1, 2'b10, 1'b0, 9'd16,  32'h0,         1'b0, 32'hAABBCCDD, 1'b0));
        vecs.push_back(mk(1'b1, 2'b01, 1'b1, 9'd19,  32'h0,         1'b0, 32'hFFFFCCDD, 1'b0));
`endif
        vecs.push_back(mk(1'b0, 2'b00, 1'b0, 9'd511, 32'h000000F0,  1'b1, 32'h0,        1'b0));
        vecs.push_back(mk(1'b1, 2'b00, 1'b0, 9'd511, 32'h0,         1'b0, 32'h000000F0, 1'b0));

        repeat (3) @(posedge main_clk);
        @(negedge main_clk);
        chk("reset moc", {31'd0, moc}, 32'd0);
        chk("reset err", {31'd0, err}, 32'd0);
        chk("reset data_out", data_out, 32'h0000_0000);
        reset = 1'b0;

        foreach (vecs[i]) begin
            run_access(vecs[i], $sformatf("vec%0d", i));
        end

        chk("mem4 untouched", {24'd0, dut.memory[4]}, 32'h11);
        chk("mem5 byte write", {24'd0, dut.memory[5]}, 32'h80);
        chk("mem6 untouched", {24'd0, dut.memory[6]}, 32'h33);
        chk("mem8 half hi", {24'd0, dut.memory[8]}, 32'h12);
        chk("mem9 half lo", {24'd0, dut.memory[9]}, 32'h34);
        chk("mem10 untouched", {24'd0, dut.memory[10]}, 32'h5A);
`ifdef RAM_ALIGN_CHECK_EN
        chk("mem16 word", {24'd0, dut.memory[16]}, 32'h01);
        chk("mem19 word", {24'd0, dut.memory[19]}, 32'h04);
`else
        chk("mem16 word", {24'd0, dut.memory[16]}, 32'hAA);
        chk("mem19 word", {24'd0, dut.memory[19]}, 32'hDD);
`endif
        chk("mem511 byte", {24'd0, dut.memory[511]}, 32'hF0);

        // mfa held through DONE: moc stays high and the write is not repeated.
        start_req(mk(1'b0, 2'b00, 1'b0, 9'd20, 32'h00000077, 1'b1, 32'h0, 1'b0));
        wait_done("hold");
        chk("hold first write", {24'd0, dut.memory[20]}, 32'h77);
        @(negedge main_clk);
        dut.memory[20] <= 8'h00;
        rw      = 1'b0;
        size    = 2'b00;
        address = 9'd21;
        data_in = 32'h00000055;
        for (int k = 0; k < 5; k++) begin
            @(posedge main_clk);
            #1;
            chk($sformatf("hold moc cycle%0d", k), {31'd0, moc}, 32'd1);
        end
        chk("hold no rewrite", {24'd0, dut.memory[20]}, 32'h00);
        chk("hold no new write", {24'd0, dut.memory[21]}, 32'h00);
        release_req("hold");

        // Reset during WAIT of a write drops it without touching memory.
        @(negedge main_clk);
        mfa      = 1'b1;
        rw       = 1'b0;
        size     = 2'b00;
        sign_ext = 1'b0;
        address  = 9'd12;
        data_in  = 32'h00000099;
        @(posedge main_clk);
        @(negedge main_clk);
        reset = 1'b1;
        mfa   = 1'b0;
        @(posedge main_clk);
        #1;
        chk("midreset moc", {31'd0, moc}, 32'd0);
        chk("midreset err", {31'd0, err}, 32'd0);
        chk("midreset data_out", data_out, 32'h0000_0000);
        model_dout = 32'h0000_0000;
        @(negedge main_clk);
        reset = 1'b0;
        repeat (3) @(posedge main_clk);
        #1;
        chk("midreset mem12", {24'd0, dut.memory[12]}, 32'hC3);
        chk("midreset idle moc", {31'd0, moc}, 32'd0);
        run_access(mk(1'b1, 2'b00, 1'b1, 9'd12, 32'h0, 1'b0, 32'hFFFFFFC3, 1'b0), "post_reset_rd");
        run_access(mk(1'b0, 2'b00, 1'b0, 9'd12, 32'h00000099, 1'b1, 32'h0, 1'b0), "post_reset_wr");
        run_access(mk(1'b1, 2'b00, 1'b0, 9'd12, 32'h0, 1'b0, 32'h00000099, 1'b0), "post_reset_rd2");

        chk("scoreboard empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
